// File: rtl/pa_core_pcgen_bp_pkg.sv
// Shared constants and types for the PC generator and its branch target buffer.
package pa_core_pcgen_bp_pkg;

  localparam logic [31:0] PA_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_ALLOC = CTR_WT;

  // Two-bit saturating direction counter.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      default: n = taken ? CTR_ST  : CTR_WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pa_core_pcgen_bp_if.sv
// Fetch-address handshake between the PC generator (master) and the fetch stage.
interface pa_core_pcgen_bp_if #(
  parameter int unsigned XLEN = 32
);
  logic            pc_valid_o;
  logic            pc_ready_i;
  logic [XLEN-1:0] pc_o;
  logic            pred_taken_o;

  modport master (output pc_valid_o, output pc_o, output pred_taken_o, input pc_ready_i);
  modport slave  (input pc_valid_o, input pc_o, input pred_taken_o, output pc_ready_i);
endinterface

// File: rtl/pa_core_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered training, bulk clear.
module pa_core_btb
  import pa_core_pcgen_bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 8
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            lk_hit_o,
  output logic            lk_taken_o,
  output logic [XLEN-1:0] lk_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);
  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] vld_q;
  logic [TAGW-1:0]    tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];

  logic [IDX-1:0]  lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            up_hit;
  logic            unused_lsb;

  assign lk_idx = lk_pc_i[IDX+1:2];
  assign lk_tag = lk_pc_i[XLEN-1:IDX+2];
  assign up_idx = upd_pc_i[IDX+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX+2];
  assign unused_lsb = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_hit_o    = vld_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign lk_taken_o  = ctr_q[lk_idx][1];
  assign lk_target_o = tgt_q[lk_idx];
  assign up_hit      = vld_q[up_idx] & (tag_q[up_idx] == up_tag);

  // Lookup reads the pre-edge arrays, so a same-cycle update is only seen next cycle.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      ctr_q <= '{default: CTR_SNT};
    end else if (upd_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
        if (upd_taken_i) tgt_q[up_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        vld_q[up_idx] <= 1'b1;
        ctr_q[up_idx] <= CTR_ALLOC;
        tag_q[up_idx] <= up_tag;
        tgt_q[up_idx] <= upd_target_i;
      end
    end
  end

endmodule

// File: rtl/pa_core_pcgen_bp.sv
// Program-counter generator: redirect/reset priority mux, fetch handshake, misalign check, BTB prediction.
module pa_core_pcgen_bp
  import pa_core_pcgen_bp_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = XLEN'(PA_RESET_ADDR),
  parameter int unsigned     BTB_ENTRIES = 8,
  parameter logic            C_EXT       = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reset_flag_i,
  input  logic                 hold_flag_i,
  input  logic                 jump_flag_i,
  input  logic [XLEN-1:0]      jump_addr_i,
  pa_core_pcgen_bp_if.master   fetch_if,
  input  logic                 upd_valid_i,
  input  logic [XLEN-1:0]      upd_pc_i,
  input  logic [XLEN-1:0]      upd_target_i,
  input  logic                 upd_taken_i,
  output logic                 misalign_o,
  output logic [XLEN-1:0]      misalign_addr_o
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic            run_q;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic            btb_hit, btb_taken;
  logic [XLEN-1:0] btb_target;
  logic            valid, fire, pred, jump_misal;

  assign valid      = run_q & ~hold_flag_i;
  assign fire       = valid & fetch_if.pc_ready_i;
  assign pred       = valid & btb_hit & btb_taken;
  assign jump_misal = jump_addr_i[0] | (~C_EXT & jump_addr_i[1]);

  pa_core_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i        (clk_i),
    .clr_i        (rst_i | reset_flag_i),
    .lk_pc_i      (pc_q),
    .lk_hit_o     (btb_hit),
    .lk_taken_o   (btb_taken),
    .lk_target_o  (btb_target),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i)
  );

  // Hold needs no branch: fire is already gated by it.
  always_comb begin
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    if (reset_flag_i) begin
      pc_d = RESET_ADDR;
    end else if (jump_flag_i) begin
      if (jump_misal) begin
        mis_d      = 1'b1;
        mis_addr_d = jump_addr_i;
      end else begin
        pc_d = jump_addr_i;
      end
    end else if (fire) begin
      pc_d = pred ? btb_target : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_ADDR;
      run_q      <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= 1'b1;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign fetch_if.pc_valid_o   = valid;
  assign fetch_if.pc_o         = pc_q;
  assign fetch_if.pred_taken_o = pred;
  assign misalign_o            = mis_q;
  assign misalign_addr_o       = mis_addr_q;

endmodule

// File: tb/tb_pa_core_pcgen_bp.sv
// Two DUTs (C_EXT=0 and C_EXT=1) on shared stimulus, each checked against its own behavioural model.
module tb_pa_core_pcgen_bp;
  localparam int NE = 8;

  logic        clk;
  logic        rst, rflag, hold, jmp;
  logic [31:0] jaddr;
  logic        upd_v, upd_tk;
  logic [31:0] upd_pc, upd_tgt;
  logic        mis0, mis1;
  logic [31:0] misa0, misa1;

  int checks = 0;
  int failures = 0;

  pa_core_pcgen_bp_if #(.XLEN(32)) f0 ();
  pa_core_pcgen_bp_if #(.XLEN(32)) f1 ();

  pa_core_pcgen_bp #(.XLEN(32), .RESET_ADDR(32'h0), .BTB_ENTRIES(NE), .C_EXT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .reset_flag_i(rflag), .hold_flag_i(hold),
    .jump_flag_i(jmp), .jump_addr_i(jaddr), .fetch_if(f0),
    .upd_valid_i(upd_v), .upd_pc_i(upd_pc), .upd_target_i(upd_tgt), .upd_taken_i(upd_tk),
    .misalign_o(mis0), .misalign_addr_o(misa0));

  pa_core_pcgen_bp #(.XLEN(32), .RESET_ADDR(32'h0), .BTB_ENTRIES(NE), .C_EXT(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .reset_flag_i(rflag), .hold_flag_i(hold),
    .jump_flag_i(jmp), .jump_addr_i(jaddr), .fetch_if(f1),
    .upd_valid_i(upd_v), .upd_pc_i(upd_pc), .upd_target_i(upd_tgt), .upd_taken_i(upd_tk),
    .misalign_o(mis1), .misalign_addr_o(misa1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, index [k] = model of dutk
  logic [31:0] m_pc   [2];
  bit          m_run  [2];
  bit          m_mis  [2];
  logic [31:0] m_misa [2];
  bit          b_v    [2][NE];
  logic [31:0] b_tag  [2][NE];
  logic [31:0] b_tgt  [2][NE];
  int          b_ctr  [2][NE];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'((a / 4) % NE);
  endfunction

  function automatic logic [31:0] btag(input logic [31:0] a);
    return a / (4 * NE);
  endfunction

  task automatic model_clear(input int k);
    for (int e = 0; e < NE; e++) begin
      b_v[k][e] = 0;
      b_ctr[k][e] = 0;
    end
  endtask

  task automatic model_reset_all();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_run[k] = 0; m_mis[k] = 0; m_misa[k] = 32'h0;
      model_clear(k);
    end
  endtask

  task automatic step(input bit r, input bit rf, input bit h, input bit j, input logic [31:0] ja,
                      input bit rd, input bit uv, input logic [31:0] up, input logic [31:0] ut,
                      input bit utk);
    rst = r; rflag = rf; hold = h; jmp = j; jaddr = ja;
    f0.pc_ready_i = rd; f1.pc_ready_i = rd;
    upd_v = uv; upd_pc = up; upd_tgt = ut; upd_tk = utk;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit v, hit, pr, misal, uhit;
      int ix, ui;
      logic [31:0] o_pc, o_misa;
      logic o_v, o_pr, o_mis;
      ix  = bidx(m_pc[k]);
      v   = m_run[k] && !h;
      hit = b_v[k][ix] && (b_tag[k][ix] == btag(m_pc[k]));
      pr  = v && hit && (b_ctr[k][ix] >= 2);
      o_pc   = (k == 0) ? f0.pc_o : f1.pc_o;
      o_v    = (k == 0) ? f0.pc_valid_o : f1.pc_valid_o;
      o_pr   = (k == 0) ? f0.pred_taken_o : f1.pred_taken_o;
      o_mis  = (k == 0) ? mis0 : mis1;
      o_misa = (k == 0) ? misa0 : misa1;
      check_eq($sformatf("pc%0d", k), o_pc, m_pc[k]);
      check_eq($sformatf("valid%0d", k), 32'(o_v), 32'(v));
      check_eq($sformatf("pred%0d", k), 32'(o_pr), 32'(pr));
      check_eq($sformatf("mis%0d", k), 32'(o_mis), 32'(m_mis[k]));
      check_eq($sformatf("misaddr%0d", k), o_misa, m_misa[k]);
      if (r) begin
        m_pc[k] = 32'h0; m_run[k] = 0; m_mis[k] = 0; m_misa[k] = 32'h0;
        model_clear(k);
      end else begin
        m_run[k] = 1; m_mis[k] = 0;
        if (rf) begin
          m_pc[k] = 32'h0;
          model_clear(k);
        end else begin
          if (j) begin
            misal = ja[0] || (k == 0 && ja[1]);
            if (misal) begin m_mis[k] = 1; m_misa[k] = ja; end
            else m_pc[k] = ja;
          end else if (v && rd) begin
            m_pc[k] = pr ? b_tgt[k][ix] : m_pc[k] + 32'd4;
          end
          if (uv) begin
            ui   = bidx(up);
            uhit = b_v[k][ui] && (b_tag[k][ui] == btag(up));
            if (uhit) begin
              if (utk) begin
                b_ctr[k][ui] = (b_ctr[k][ui] == 3) ? 3 : b_ctr[k][ui] + 1;
                b_tgt[k][ui] = ut;
              end else begin
                b_ctr[k][ui] = (b_ctr[k][ui] == 0) ? 0 : b_ctr[k][ui] - 1;
              end
            end else if (utk) begin
              b_v[k][ui] = 1; b_ctr[k][ui] = 2; b_tag[k][ui] = btag(up); b_tgt[k][ui] = ut;
            end
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic go(input bit rd);
    step(0, 0, 0, 0, 32'h0, rd, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic jump_to(input logic [31:0] a);
    step(0, 0, 0, 1, a, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic train(input logic [31:0] p, input logic [31:0] t, input bit tk);
    step(0, 0, 0, 0, 32'h0, 0, 1, p, t, tk);
  endtask

  task automatic pc_both(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    #1;
    check_eq({tag, "_0"}, f0.pc_o, e0);
    check_eq({tag, "_1"}, f1.pc_o, e1);
  endtask

  initial begin
    rst = 1; rflag = 0; hold = 0; jmp = 0; jaddr = 0;
    f0.pc_ready_i = 0; f1.pc_ready_i = 0;
    upd_v = 0; upd_pc = 0; upd_tgt = 0; upd_tk = 0;
    @(negedge clk);
    model_reset_all();
    step(1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0);

    repeat (5) go(1);
    pc_both("stream", 32'h10, 32'h10);
    repeat (4) go(0);
    pc_both("stall", 32'h10, 32'h10);
    repeat (2) step(0, 0, 1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
    pc_both("hold", 32'h10, 32'h10);
    go(1);
    pc_both("after_hold", 32'h14, 32'h14);

    jump_to(32'h200);
    pc_both("jump_al", 32'h200, 32'h200);
    jump_to(32'h202);
    pc_both("jump_mis", 32'h200, 32'h202);
    check_eq("mis_pulse", 32'(mis0), 32'h1);
    check_eq("mis_addr", misa0, 32'h202);
    go(0);
    step(0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    train(32'h40, 32'h100, 1);
    jump_to(32'h40);
    go(1);
    pc_both("btb_taken", 32'h100, 32'h100);
    train(32'h40, 32'h0, 0);
    train(32'h40, 32'h0, 0);
    jump_to(32'h40);
    go(1);
    pc_both("btb_off", 32'h44, 32'h44);

    train(32'h40, 32'h100, 1);
    train(32'h60, 32'h180, 1);
    jump_to(32'h40);
    go(1);
    pc_both("alias_miss", 32'h44, 32'h44);
    jump_to(32'h60);
    go(1);
    pc_both("alias_new", 32'h180, 32'h180);

    train(32'h40, 32'h100, 1);
    step(0, 1, 0, 1, 32'h300, 0, 0, 32'h0, 32'h0, 0);
    pc_both("rflag_wins", 32'h0, 32'h0);
    jump_to(32'h40);
    go(1);
    pc_both("btb_cleared", 32'h44, 32'h44);

    step(0, 0, 1, 1, 32'h80, 1, 0, 32'h0, 32'h0, 0);
    pc_both("jump_hold", 32'h80, 32'h80);
    jump_to(32'hFFFF_FFFC);
    go(1);
    pc_both("wrap", 32'h0, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      bit r, rf, h, j, rd, uv, tk;
      logic [31:0] ja, up, ut;
      r  = ($urandom_range(99) < 2);
      rf = ($urandom_range(99) < 3);
      h  = ($urandom_range(99) < 15);
      j  = ($urandom_range(99) < 10);
      rd = ($urandom_range(99) < 75);
      uv = ($urandom_range(99) < 35);
      tk = ($urandom_range(99) < 60);
      ja = ($urandom_range(19) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(255));
      up = 32'($urandom_range(31)) << 2;
      ut = 32'($urandom_range(255)) & 32'hFFFF_FFFC;
      step(r, rf, h, j, ja, rd, uv, up, ut, tk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pa_core_pcgen_bp.md
# pa_core_pcgen_bp

Parametrised program-counter generator with fetch handshake and a direct-mapped branch target buffer (BTB). It sits at the front of the core pipeline, ahead of instruction fetch. Each cycle it offers one fetch address, plus a taken prediction, to the fetch stage. It accepts redirects, stalls and software reset from the pipeline control, and BTB training updates from execute.

## Interface
- `XLEN`, default 32: address width.
- `RESET_ADDR`, default `32'h0000_0000`: PC value after any reset.
- `BTB_ENTRIES`, default 8: BTB depth; must be a power of two and ≥2. `IDX = log2(BTB_ENTRIES)`.
- `C_EXT`, default 0: 1 = 2-byte target alignment legal; 0 = 4-byte alignment required.

Ports:
- `clk_i` in 1: core clock.
- `rst_i` in 1: synchronous, active-high reset.
- `reset_flag_i` in 1: software reset request.
- `hold_flag_i` in 1: pipeline stall.
- `jump_flag_i` in 1: redirect request.
- `jump_addr_i` in XLEN: redirect target.
- `pc_valid_o` out 1: fetch address valid.
- `pc_ready_i` in 1: fetch stage accepts the address.
- `pc_o` out XLEN: fetch address.
- `pred_taken_o` out 1: BTB predicts `pc_o` is a taken branch.
- `upd_valid_i` in 1: BTB training strobe from execute.
- `upd_pc_i` in XLEN: address of the resolved branch.
- `upd_target_i` in XLEN: resolved target.
- `upd_taken_i` in 1: resolved direction.
- `misalign_o` out 1: one-cycle pulse on a rejected misaligned redirect.
- `misalign_addr_o` out XLEN: offending target; held until the next pulse.

## Operation
- **State.** `pc_q`, `run_q`, the BTB array, `misalign_o`, `misalign_addr_o`.
- **Fire.** `fire = pc_valid_o & pc_ready_i`.
- **Valid.** `pc_valid_o = run_q & ~hold_flag_i`.
- **Next-PC priority**, highest first:
  1. `rst_i`
  2. `reset_flag_i`
  3. `jump_flag_i`
  4. `hold_flag_i`
  5. `fire`
  6. keep current PC
- **Resets.**
  - `rst_i` and `reset_flag_i`: `pc_q=RESET_ADDR`, all BTB valid bits cleared, counters=0.
  - `rst_i` additionally clears `run_q`, `misalign_o` and `misalign_addr_o`.
  - `reset_flag_i` leaves `run_q` set.
- **Jump.**
  - Misaligned target: `jump_addr_i[0]`, or `jump_addr_i[1]` when `C_EXT=0`.
  - Aligned: `pc_q` takes `jump_addr_i`.
  - Misaligned: `pc_q` is unchanged, `misalign_o=1` for one cycle, `misalign_addr_o=jump_addr_i`.
- **Fire.** `pc_q` takes `pred_taken_o ? btb_target : pc_q+4`. The sum wraps modulo 2^XLEN.
- **BTB lookup** (combinational on `pc_q`):
  - Index `pc_q[IDX+1:2]`; tag `pc_q[XLEN-1:IDX+2]`.
  - Hit = valid & tag match.
  - `pred_taken_o = hit & ctr[1]`.
  - `pred_taken_o` is 0 whenever `pc_valid_o=0`.
- **BTB update** (on `upd_valid_i`):
  - Hit: 2-bit saturating counter increments if taken, decrements if not. Target is rewritten when taken.
  - Miss and taken: allocate the entry (overwrite) with valid=1, `ctr=2'b10`, new tag and target.
  - Miss and not taken: no change.
- **Update vs. reset.** An update in the same cycle as `rst_i`/`reset_flag_i` is dropped.
- **Update vs. lookup.** Same-cycle update and lookup of one index: the lookup sees old contents. There is no bypass.

## Timing
- **Reset values.** `pc_o=RESET_ADDR`, `pc_valid_o=0`, `pred_taken_o=0`, `misalign_o=0`, `misalign_addr_o=0`.
- **Leaving reset.** `pc_valid_o` rises the first cycle after `rst_i` deasserts, unless held.
- **Redirect latency.** `pc_o` shows the redirect/reset target one cycle after the request.
- **Fetch stream.** One fetch per cycle at full throughput.
- **Handshake.**
  - While `pc_valid_o & ~pc_ready_i`, `pc_o` and `pred_taken_o` are stable, unless a jump or reset overrides.
  - A jump during a stalled handshake replaces the pending address. The old address is never re-offered.
- **BTB training.** An update is visible to lookup the cycle after `upd_valid_i`.
- **Mid-operation reset.** A reset or `reset_flag_i` during any state takes effect next cycle, regardless of `hold_flag_i` or `pc_ready_i`.

## Structure
- Counter encodings (`2'b00`..`2'b11`, allocate value `2'b10`) and the default `RESET_ADDR` go in the shared `pa_chip_param.v` constants.
- Sub-module `pa_core_btb` holds the storage: arrays, lookup port, update port and the clear input.
- The PC register, priority mux, handshake and misalign check stay in `pa_core_pcgen_bp`.

## Test plan
- **Reset.** Assert `rst_i` 3 cycles, then release with `pc_ready_i=1` → `pc_o` = 0, 0, 4, 8…; `pc_valid_o` rises on the first cycle after release.
- **Handshake and hold.** Drop `pc_ready_i` at `pc_o=0x10` for 4 cycles → `pc_o` stays `0x10`. Assert `hold_flag_i` → `pc_valid_o=0`, PC frozen. Release → `0x14` follows.
- **Redirects.** Aligned jump to `0x200` with `C_EXT=0` → `pc_o=0x200` next cycle. Jump to `0x202` → PC unchanged, `misalign_o` pulses once, `misalign_addr_o=0x202`. With `C_EXT=1`, `0x202` is accepted.
- **BTB training.** Update `pc=0x40`, `target=0x100`, taken → reaching `0x40` gives `pred_taken_o=1` and next `pc_o=0x100`. Two not-taken updates → prediction off, next is `0x44`.
- **BTB aliasing.** With `BTB_ENTRIES=8`, train `0x40` then `0x60` (same index) → `0x40` no longer hits.
- **Simultaneous events.** Jump and `reset_flag_i` in the same cycle → `RESET_ADDR` wins and the BTB is cleared. Jump and `hold_flag_i` → jump taken. PC `0xFFFF_FFFC` fires → wraps to `0`.
